// File: rtl/cube_scan_sequencer.sv
// ---------------------------------------------------------------------------
// cube_scan_sequencer
//
// Purpose: scans an 8x8x8 LED cube one layer at a time. For each layer it
// blanks the layer drivers, reads the eight row bytes of that layer from a
// frame buffer, latches each byte into its row register, and then lights the
// layer with a brightness-controlled PWM on-time. After layer 7 the scan wraps
// to layer 0 and frame_done pulses.
//
// Parameters:
//   LATCH_CYC  - cycles each row latch enable is held high (>= 1)
//   BLANK_CYC  - all-layers-off cycles before each layer load (>= 1)
//   LAYER_HOLD - layer PWM period in cycles (multiple of 16, >= 16)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   enable     in   scanning runs while high; low forces IDLE next edge
//   brightness in   [3:0] layer on-time select, sampled on layer-on entry
//   fb_rd      out  one-cycle frame-buffer read strobe
//   fb_addr    out  [5:0] frame-buffer address {layer, row}
//   fb_data    in   [7:0] read data, valid the cycle after fb_rd
//   Layers     out  [7:0] one-hot layer enable or zero
//   Latches    out  [7:0] one-hot row latch enable or zero
//   Data       out  [7:0] row data bus
//   frame_done out  one-cycle pulse on the first BLANK after layer 7
//   busy       out  high whenever the sequencer is not idle
//
// Every output is a flop. The next-state logic computes the next state and
// counters, and the output flops are loaded from decodes of those next
// values, so each output lines up with the state it belongs to.
// ---------------------------------------------------------------------------
module cube_scan_sequencer #(
  parameter int LATCH_CYC  = 2,
  parameter int BLANK_CYC  = 2,
  parameter int LAYER_HOLD = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] brightness,
  output logic       fb_rd,
  output logic [5:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic [7:0] Layers,
  output logic [7:0] Latches,
  output logic [7:0] Data,
  output logic       frame_done,
  output logic       busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_BLANK     = 3'd1;
  localparam logic [2:0] S_LOAD_REQ  = 3'd2;
  localparam logic [2:0] S_LOAD_WAIT = 3'd3;
  localparam logic [2:0] S_LATCH     = 3'd4;
  localparam logic [2:0] S_HOLD      = 3'd5;
  localparam logic [2:0] S_LAYER_ON  = 3'd6;

  // One shared cycle counter serves BLANK, LATCH and LAYER_ON; it must hold
  // the largest of the three durations. LAYER_HOLD itself must also fit,
  // since the on-time can equal the full period.
  localparam int MAXC_BL = (BLANK_CYC > LATCH_CYC) ? BLANK_CYC : LATCH_CYC;
  localparam int MAXC    = (LAYER_HOLD > MAXC_BL) ? LAYER_HOLD : MAXC_BL;
  localparam int CNT_W   = $clog2(MAXC + 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_layer;
  logic [2:0]       r_row;
  logic [CNT_W-1:0] r_on;

  logic             r_fb_rd;
  logic [5:0]       r_fb_addr;
  logic [7:0]       r_layers;
  logic [7:0]       r_latches;
  logic [7:0]       r_data;
  logic             r_frame_done;
  logic             r_busy;

  logic [2:0]       w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [2:0]       w_layer_nx;
  logic [2:0]       w_row_nx;
  logic [CNT_W-1:0] w_on_nx;
  logic [CNT_W-1:0] w_on_calc;
  logic             w_load_data;
  logic             w_frame_nx;
  logic [5:0]       w_addr_nx;
  logic [7:0]       w_layers_nx;
  logic [7:0]       w_latches_nx;

  // on_cycles = (brightness + 1) * (LAYER_HOLD / 16); never exceeds LAYER_HOLD
  assign w_on_calc = CNT_W'((32'(brightness) + 32'd1) * 32'(LAYER_HOLD / 16));

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_layer_nx  = r_layer;
    w_row_nx    = r_row;
    w_on_nx     = r_on;
    w_load_data = 1'b0;
    w_frame_nx  = 1'b0;
    case (r_state)
      // Disable is handled in the register block, so reaching here means
      // enable is high and a fresh scan starts.
      S_IDLE: begin
        w_state_nx = S_BLANK;
        w_cnt_nx   = '0;
        w_layer_nx = 3'd0;
        w_row_nx   = 3'd0;
      end
      S_BLANK: begin
        if (r_cnt == CNT_W'(BLANK_CYC - 1)) begin
          w_state_nx = S_LOAD_REQ;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_LOAD_REQ: begin
        w_state_nx = S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        // fb_data is valid during this cycle and is captured at its end
        w_load_data = 1'b1;
        w_state_nx  = S_LATCH;
        w_cnt_nx    = '0;
      end
      S_LATCH: begin
        if (r_cnt == CNT_W'(LATCH_CYC - 1)) begin
          w_state_nx = S_HOLD;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (r_row == 3'd7) begin
          w_state_nx = S_LAYER_ON;
          w_row_nx   = 3'd0;
          w_cnt_nx   = '0;
          // brightness is captured only here so mid-layer changes wait
          w_on_nx    = w_on_calc;
        end else begin
          w_state_nx = S_LOAD_REQ;
          w_row_nx   = r_row + 3'd1;
        end
      end
      S_LAYER_ON: begin
        if (r_cnt == CNT_W'(LAYER_HOLD - 1)) begin
          w_state_nx = S_BLANK;
          w_cnt_nx   = '0;
          w_layer_nx = r_layer + 3'd1;
          w_frame_nx = (r_layer == 3'd7);
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
        w_layer_nx = 3'd0;
        w_row_nx   = 3'd0;
      end
    endcase
  end

  // Output decodes from the next-state values; Latches and Layers come from
  // different states, so they can never be nonzero together.
  always_comb begin
    w_layers_nx  = 8'h00;
    w_latches_nx = 8'h00;
    w_addr_nx    = r_fb_addr;
    if (w_state_nx == S_LAYER_ON && w_cnt_nx < w_on_nx) begin
      w_layers_nx = 8'h01 << w_layer_nx;
    end
    if (w_state_nx == S_LATCH) begin
      w_latches_nx = 8'h01 << w_row_nx;
    end
    if (w_state_nx == S_LOAD_REQ) begin
      w_addr_nx = {w_layer_nx, w_row_nx};
    end
  end

  always_ff @(posedge clk) begin
    // Reset wins over enable; a dropped enable clears everything the same way,
    // which also discards any read that was in flight.
    if (!rst_n || !enable) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_layer      <= 3'd0;
      r_row        <= 3'd0;
      r_on         <= '0;
      r_fb_rd      <= 1'b0;
      r_fb_addr    <= 6'd0;
      r_layers     <= 8'h00;
      r_latches    <= 8'h00;
      r_data       <= 8'h00;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_layer      <= w_layer_nx;
      r_row        <= w_row_nx;
      r_on         <= w_on_nx;
      r_fb_rd      <= (w_state_nx == S_LOAD_REQ);
      r_fb_addr    <= w_addr_nx;
      r_layers     <= w_layers_nx;
      r_latches    <= w_latches_nx;
      r_frame_done <= w_frame_nx;
      r_busy       <= (w_state_nx != S_IDLE);
      if (w_load_data) begin
        r_data <= fb_data;
      end
    end
  end

  assign fb_rd      = r_fb_rd;
  assign fb_addr    = r_fb_addr;
  assign Layers     = r_layers;
  assign Latches    = r_latches;
  assign Data       = r_data;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule

// File: doc/cube_scan_sequencer.md
CUBE_SCAN_SEQUENCER -- requirements
Module: cube_scan_sequencer

Interface
REQ-001 SHALL have parameter LATCH_CYC, default 2: number of cycles a latch-enable bit is held high per row.
REQ-002 SHALL have parameter BLANK_CYC, default 2: number of all-layers-off cycles before each layer load.
REQ-003 SHALL have parameter LAYER_HOLD, default 64: layer PWM period in cycles; must be a multiple of 16 and at least 16.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: scanning runs while this is high.
REQ-007 SHALL have port brightness, input, 4 bits: layer on-time select; 0 is the dimmest setting and 15 is full on-time.
REQ-008 SHALL have port fb_rd, output, 1 bit: one-cycle frame-buffer read strobe.
REQ-009 SHALL have port fb_addr, output, 6 bits: frame-buffer address {layer[2:0], row[2:0]}.
REQ-010 SHALL have port fb_data, input, 8 bits: read data, valid exactly 1 cycle after fb_rd.
REQ-011 SHALL have port Layers, output, 8 bits: one-hot layer enable, or zero.
REQ-012 SHALL have port Latches, output, 8 bits: one-hot row latch enable, or zero.
REQ-013 SHALL have port Data, output, 8 bits: row data bus.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse after layer 7 on-period ends.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, BLANK, LOAD_REQ, LOAD_WAIT, LATCH, HOLD, LAYER_ON.
REQ-017 IDLE SHALL go to BLANK when enable=1, with layer=0 and row=0.
REQ-018 BLANK SHALL drive Layers=0, Latches=0 for BLANK_CYC cycles, then go to LOAD_REQ.
REQ-019 LOAD_REQ SHALL assert fb_rd=1 with fb_addr={layer,row} for 1 cycle, then go to LOAD_WAIT.
REQ-020 LOAD_WAIT SHALL register fb_data into Data at the end of the cycle, then go to LATCH.
REQ-021 LATCH SHALL drive Latches=(8'h01<<row) for LATCH_CYC cycles with Data stable, then go to HOLD.
REQ-022 HOLD SHALL drive Latches=0 for 1 cycle with Data unchanged; it then goes to LOAD_REQ with row+1 if row<7, else to LAYER_ON with row=0.
REQ-023 One row load SHALL take exactly 3+LATCH_CYC cycles.
REQ-024 Brightness SHALL be sampled once on entry to LAYER_ON; on_cycles=(brightness+1)*(LAYER_HOLD/16).
REQ-025 LAYER_ON SHALL last LAYER_HOLD cycles, driving Layers=(8'h01<<layer) for the first on_cycles cycles and 0 for the remainder.
REQ-026 At the end of LAYER_ON, layer SHALL increment modulo 8 and the FSM SHALL go to BLANK.
REQ-027 When the layer wraps from 7 to 0, frame_done SHALL pulse high for exactly 1 cycle, coincident with the first BLANK cycle.
REQ-028 Latches and Layers SHALL never both be nonzero in the same cycle.
REQ-029 fb_rd SHALL be high only in LOAD_REQ.
REQ-030 enable=0 in any state SHALL force IDLE on the next edge: Layers, Latches, Data, fb_rd, busy all 0, counters cleared.
REQ-031 enable=0 SHALL abandon any in-flight read; fb_data on the following cycle SHALL be ignored.
REQ-032 Re-enable SHALL always restart at layer 0, row 0, BLANK.
REQ-033 A brightness change mid-LAYER_ON SHALL have no effect until the next LAYER_ON entry.
REQ-034 All outputs SHALL be registered.
REQ-035 Internal counters SHALL be wide enough for LAYER_HOLD without overflow.

Reset
REQ-036 rst_n=0 SHALL, at the next clock edge, set the state to IDLE and clear layer, row and counters.
REQ-037 rst_n=0 SHALL, at the next clock edge, drive Layers, Latches, Data, fb_addr, fb_rd, frame_done and busy to 0.
REQ-038 Reset SHALL take priority over enable.
REQ-039 Reset mid-operation SHALL abort the scan with no residual latch or layer pulse.

Verification
REQ-040 Reset scenario: hold rst_n=0 with enable=1 for 3 cycles -> all outputs 0 every cycle; after release, BLANK starts 1 cycle later.
REQ-041 Row-load scenario: enable=1, fb_data=8'hA5 for addr 6'h00 -> fb_rd after 2 BLANK cycles; Data=8'hA5 with Latches=8'h01 for 2 cycles; next fb_addr=6'h01 after the HOLD cycle.
REQ-042 PWM scenario: brightness=15 -> Layers=8'h01 for 64 cycles; brightness=3 -> Layers=8'h01 for 16 cycles then 0 for 48 cycles.
REQ-043 Wrap scenario: complete layer 7 -> frame_done pulses for 1 cycle; next fb_addr=6'h00; Layers for the following layer=8'h01.
REQ-044 Abort scenario: drop enable during LATCH of row 4, layer 2 -> next cycle all outputs 0; re-enable -> first fb_addr=6'h00.
REQ-045 Brightness-hold scenario: change brightness 15->0 mid-LAYER_ON -> current layer keeps 64 on-cycles; next layer gets 4 on-cycles.
